hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and forwarding controller for the five-stage RV32I pipeline. It decodes source and destination registers at the ID stage and keeps a shadow copy of the destination, write-enable and load flags for EX, MEM and WB. From that state it produces:
- load-use stalls for IF/ID,
- flushes on taken branches and jumps,
- registered forwarding selects for the EX operand muxes,
- a WB-to-ID register-file bypass,
- saturating stall and flush event counters.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- a1  input  5  rs1 of the instruction in ID
- a2  input  5  rs2 of the instruction in ID
- RdD  input  5  rd of the instruction in ID
- UseRs1D  input  1  ID instruction reads rs1
- UseRs2D  input  1  ID instruction reads rs2
- RegWriteD  input  1  ID instruction writes rd
- MemReadD  input  1  ID instruction is a load
- BranchTakenE  input  1  EX instruction redirects PC (taken branch, jal or jalr)
- StallF  output  1  hold PC
- StallD  output  1  hold the IF/ID register
- FlushD  output  1  clear the IF/ID register
- FlushE  output  1  load a bubble into ID/EX
- ForwardAE  output  2  EX operand A select: 00 = register file, 01 = WB result, 10 = MEM ALU result
- ForwardBE  output  2  EX operand B select, same encoding as ForwardAE
- ForwardAD  output  1  ID rs1 read takes the WB write data
- ForwardBD  output  1  ID rs2 read takes the WB write data
- StallCount  output  CNT_W  number of cycles with ld_use stall asserted, saturating
- FlushCount  output  CNT_W  number of cycles with BranchTakenE, saturating

## Operation
Shadow state, all cleared by reset:
- EX slot: ex_rd[4:0], ex_we, ex_ld.
- MEM slot: mem_rd, mem_we.
- WB slot: wb_rd, wb_we.

Effective write enables:
- weD = RegWriteD & (RdD != 0). x0 is never a hazard source.
- ex_we, mem_we and wb_we are only ever set through weD.

Load-use detect (combinational):
- ld_use = ex_ld & ex_we & ((UseRs1D & a1==ex_rd) | (UseRs2D & a2==ex_rd)).

Control outputs (combinational, all forced to 0 while reset=1):
- StallF = StallD = ld_use & ~BranchTakenE.
- FlushD = BranchTakenE.
- FlushE = BranchTakenE | ld_use.
- A redirect has priority. The instruction in ID is wrong-path, so it is flushed, not stalled.

Shadow update on every rising edge with reset=0:
- If FlushE: the EX slot becomes a bubble (rd=0, we=0, ld=0).
- Otherwise the EX slot takes {RdD, weD, MemReadD & weD}.
- MEM takes the old EX slot; WB takes the old MEM slot. These stages never stall.

Forwarding selects (registered alongside the EX slot):
- next ForwardAE = 10 if ex_we & ex_rd==a1 & UseRs1D.
- Else 01 if mem_we & mem_rd==a1 & UseRs1D.
- Else 00.
- ForwardBE uses the same rule with a2 and UseRs2D.
- The newest producer wins (10 beats 01).
- When FlushE is asserted, both selects load 00.

ID bypass (combinational; the register file writes at the edge and ID reads in the same cycle):
- ForwardAD = wb_we & wb_rd==a1 & UseRs1D.
- ForwardBD = wb_we & wb_rd==a2 & UseRs2D.

Counters:
- StallCount increments on each cycle with StallD=1.
- FlushCount increments on each cycle with BranchTakenE=1 and reset=0.
- Both hold at 2^CNT_W-1 and never wrap.

## Timing
- Reset: every shadow field, ForwardAE, ForwardBE, StallCount and FlushCount read 0 on the cycle after the reset edge. Combinational outputs read 0 while reset is high.
- Reset mid-stall: the stall drops in the same cycle reset rises. The pending load is discarded.
- Load-use costs exactly 1 stall cycle:
  - cycle N: load in EX, consumer in ID, StallD=1, bubble enters EX;
  - cycle N+1: load in MEM, ld_use=0, consumer advances;
  - cycle N+2: consumer in EX, load in WB, ForwardAE=01.
- Back-to-back dependent ALU ops: zero stall; the consumer sees 10 in its EX cycle.
- Taken branch: FlushD and FlushE assert in the same cycle as BranchTakenE. Two wrong-path slots are killed and no stall occurs.
- Forwarding select latency is 1 cycle: it is computed in ID and valid throughout the consumer's EX cycle.

## Test plan
- Reset: hold reset 2 cycles with random inputs → all outputs 0. StallCount=FlushCount=0 after release.
- Load-use: lw x5 in ID, then add x6,x5,x7 (a1=5, UseRs1D=1) → StallF=StallD=FlushE=1 for exactly 1 cycle. ForwardAE=01 in the consumer's EX cycle. StallCount=1.
- ALU chain: add x3 then sub x4,x3,x3 → no stall; ForwardAE=ForwardBE=10. A third instruction reading x3 two slots later gets 01. Four later gets ForwardAD=1 when x3 is in WB.
- x0 and unused operands: lw x0 followed by a reader of x0, and UseRs2D=0 with a2 matching a load rd → no stall; forwarding selects stay 00.
- Branch priority: BranchTakenE=1 with a load-dependent instruction in ID → FlushD=FlushE=1, StallD=0. FlushCount increments. The next EX slot is a bubble (forwarding selects 00).
- Saturation: CNT_W=4, force 20 load-use stalls → StallCount stops at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode, redirect and hazard-control bundle between the pipeline and hazard_ctrl.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       a1, a2, RdD;
  logic             UseRs1D, UseRs2D, RegWriteD, MemReadD, BranchTakenE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output a1, a2, RdD, UseRs1D, UseRs2D, RegWriteD, MemReadD, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    input  StallCount, FlushCount
  );
  modport slave (
    input  a1, a2, RdD, UseRs1D, UseRs2D, RegWriteD, MemReadD, BranchTakenE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    output StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: load-use stall, redirect
// flush, registered EX forwarding selects, WB->ID bypass and saturating event counters.

// Per-source-operand hazard compare against the EX/MEM/WB shadow slots.
module hazard_opnd (
  input  logic [4:0] addr,
  input  logic       use_en,
  input  logic [4:0] ex_rd, mem_rd, wb_rd,
  input  logic       ex_we, ex_ld, mem_we, wb_we,
  output logic [1:0] fwd_e_nxt,
  output logic       fwd_d,
  output logic       ld_hit
);
  always_comb begin
    ld_hit    = ex_ld & ex_we & use_en & (addr == ex_rd);
    fwd_d     = wb_we & use_en & (addr == wb_rd);
    fwd_e_nxt = 2'b00;
    // newest producer wins
    if (use_en & ex_we & (addr == ex_rd))        fwd_e_nxt = 2'b10;
    else if (use_en & mem_we & (addr == mem_rd)) fwd_e_nxt = 2'b01;
  end
endmodule

module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);
  localparam int NOPND = 2;

  logic [4:0]             ex_rd, mem_rd, wb_rd;
  logic                   ex_we, ex_ld, mem_we, wb_we;
  logic [1:0]             fwd_ae, fwd_be;
  logic [CNT_W-1:0]       stall_cnt, flush_cnt;

  logic [NOPND-1:0][4:0]  addr;
  logic [NOPND-1:0]       use_en, fwd_d, ld_hit;
  logic [NOPND-1:0][1:0]  fwd_e_nxt;
  logic                   we_d, ld_use, stall, flush_e;

  assign addr   = {hif.a2, hif.a1};
  assign use_en = {hif.UseRs2D, hif.UseRs1D};

  for (genvar i = 0; i < NOPND; i++) begin : g_opnd
    hazard_opnd u_opnd (
      .addr     (addr[i]),
      .use_en   (use_en[i]),
      .ex_rd    (ex_rd),
      .mem_rd   (mem_rd),
      .wb_rd    (wb_rd),
      .ex_we    (ex_we),
      .ex_ld    (ex_ld),
      .mem_we   (mem_we),
      .wb_we    (wb_we),
      .fwd_e_nxt(fwd_e_nxt[i]),
      .fwd_d    (fwd_d[i]),
      .ld_hit   (ld_hit[i])
    );
  end

  // x0 writes never create a producer
  assign we_d    = hif.RegWriteD & (|hif.RdD);
  assign ld_use  = |ld_hit;
  // a redirect makes the ID instruction wrong-path: flush it instead of stalling
  assign stall   = ld_use & ~hif.BranchTakenE;
  assign flush_e = hif.BranchTakenE | ld_use;

  assign hif.StallF     = ~reset & stall;
  assign hif.StallD     = ~reset & stall;
  assign hif.FlushD     = ~reset & hif.BranchTakenE;
  assign hif.FlushE     = ~reset & flush_e;
  assign hif.ForwardAD  = ~reset & fwd_d[0];
  assign hif.ForwardBD  = ~reset & fwd_d[1];
  assign hif.ForwardAE  = fwd_ae;
  assign hif.ForwardBE  = fwd_be;
  assign hif.StallCount = stall_cnt;
  assign hif.FlushCount = flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      fwd_ae    <= 2'b00;
      fwd_be    <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush_e) begin
        ex_rd  <= '0;
        ex_we  <= 1'b0;
        ex_ld  <= 1'b0;
        fwd_ae <= 2'b00;
        fwd_be <= 2'b00;
      end else begin
        ex_rd  <= hif.RdD;
        ex_we  <= we_d;
        ex_ld  <= hif.MemReadD & we_d;
        fwd_ae <= fwd_e_nxt[0];
        fwd_be <= fwd_e_nxt[1];
      end
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (hif.BranchTakenE && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expected control vectors go through a scoreboard queue.
module tb_hazard_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif();
  hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .hif(hif.slave));

  // {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD}
  typedef struct {
    string      tag;
    logic [9:0] ctrl;
    bit         chk_cnt;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic step(input string tag,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                      input bit u1, input bit u2, input bit rw, input bit mr, input bit br,
                      input logic [9:0] ctrl,
                      input bit chk_cnt = 0, input int sc = 0, input int fc = 0);
    exp_t e, g;
    logic [9:0] obs;
    hif.a1 = a1; hif.a2 = a2; hif.RdD = rd;
    hif.UseRs1D = u1; hif.UseRs2D = u2; hif.RegWriteD = rw; hif.MemReadD = mr;
    hif.BranchTakenE = br;
    e.tag = tag; e.ctrl = ctrl; e.chk_cnt = chk_cnt; e.sc = CW'(sc); e.fc = CW'(fc);
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    obs = {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE,
           hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD};
    checks++;
    assert (obs === g.ctrl) else begin
      failures++;
      $error("FAIL %s ctrl got=%b want=%b", g.tag, obs, g.ctrl);
    end
    if (g.chk_cnt) begin
      checks++;
      assert (hif.StallCount === g.sc) else begin
        failures++;
        $error("FAIL %s StallCount got=%0d want=%0d", g.tag, hif.StallCount, g.sc);
      end
      checks++;
      assert (hif.FlushCount === g.fc) else begin
        failures++;
        $error("FAIL %s FlushCount got=%0d want=%0d", g.tag, hif.FlushCount, g.fc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step(input string tag);
    step(tag, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom), 10'b0, 1, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    hif.a1 = '0; hif.a2 = '0; hif.RdD = '0;
    hif.UseRs1D = 0; hif.UseRs2D = 0; hif.RegWriteD = 0; hif.MemReadD = 0;
    hif.BranchTakenE = 0;
    @(posedge clk);
    #1;
    // reset held with random inputs: everything reads zero
    rnd_step("rst0");
    rnd_step("rst1");
    reset = 1'b0;

    // load-use: one stall, consumer gets WB->EX (01) two cycles later
    step("lu_lw",    0, 0, 5,  0, 0, 1, 1, 0, 10'b0000_00_00_00, 1, 0, 0);
    step("lu_stall", 5, 7, 6,  1, 1, 1, 0, 0, 10'b1101_00_00_00);
    step("lu_adv",   5, 7, 6,  1, 1, 1, 0, 0, 10'b0000_00_00_00);
    step("lu_fwd01", 0, 0, 0,  0, 0, 0, 0, 0, 10'b0000_01_00_00, 1, 1, 0);

    // ALU chain: 10 next slot, 01 two slots later, WB->ID bypass after that
    step("alu_add",  0, 0, 3,  0, 0, 1, 0, 0, 10'b0000_00_00_00);
    step("alu_sub",  3, 3, 4,  1, 1, 1, 0, 0, 10'b0000_00_00_00);
    step("alu_10",   3, 0, 8,  1, 0, 1, 0, 0, 10'b0000_10_10_00);
    step("alu_01bp", 3, 3, 0,  1, 1, 0, 0, 0, 10'b0000_01_00_11);

    // x0 destination never hazards
    step("x0_lw",    0, 0, 0,  0, 0, 1, 1, 0, 10'b0000_00_00_00);
    step("x0_rd",    0, 0, 9,  1, 1, 1, 0, 0, 10'b0000_00_00_00);
    step("x0_ex",    0, 0, 0,  0, 0, 0, 0, 0, 10'b0000_00_00_00);

    // unused rs2 matching a load rd
    step("nu_lw",    0, 0, 10, 0, 0, 1, 1, 0, 10'b0000_00_00_00);
    step("nu_rd",    1, 10, 11, 1, 0, 1, 0, 0, 10'b0000_00_00_00);
    step("nu_ex",    0, 0, 0,  0, 0, 0, 0, 0, 10'b0000_00_00_00);

    // redirect beats load-use
    step("br_lw",    0, 0, 12, 0, 0, 1, 1, 0, 10'b0000_00_00_00);
    step("br_take",  12, 0, 13, 1, 0, 1, 0, 1, 10'b0011_00_00_00);
    step("br_bub",   0, 0, 0,  0, 0, 0, 0, 0, 10'b0000_00_00_00, 1, 1, 1);

    // reset during a would-be stall
    step("rm_lw",    0, 0, 5,  0, 0, 1, 1, 0, 10'b0000_00_00_00);
    reset = 1'b1;
    step("rm_rst",   5, 0, 6,  1, 0, 1, 0, 0, 10'b0000_00_00_00);
    reset = 1'b0;
    step("rm_post",  5, 0, 6,  1, 0, 1, 0, 0, 10'b0000_00_00_00, 1, 0, 0);

    // 20 load-use stalls; StallCount saturates at 15
    for (int k = 1; k <= 20; k++) begin
      step($sformatf("sat_lw%0d", k),  0, 0, 5, 0, 0, 1, 1, 0, 10'b0000_00_00_00);
      step($sformatf("sat_st%0d", k),  5, 0, 6, 1, 0, 1, 0, 0, 10'b1101_00_00_00);
      step($sformatf("sat_nop%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000_00_00_00,
           1, (k > 15) ? 15 : k, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
